cpu_fetch_unit: RTL

//  Instruction fetch stage directly upstream of the CPU instruction register.

---
 rtl/cpu_fetch_unit_pkg.sv | 23 ++
 rtl/cpu_pc_reg.sv | 48 ++++
 rtl/cpu_fetch_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// cpu_fetch_unit_pkg
// Shared definitions for the instruction fetch stage.
//   XLEN        : architectural register / address width
//   INST_BYTES  : bytes per instruction word (PC increment)
//   fetch_state_e : FETCH_IDLE / FETCH_BUSY state encodings
//   is_misaligned : true when an address is not word aligned
// -----------------------------------------------------------------------------
package cpu_fetch_unit_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_BUSY = 1'b1
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/cpu_pc_reg.sv
// -----------------------------------------------------------------------------
// cpu_pc_reg
// Program counter register with redirect mux and +4 incrementer.
//   clk, rst        : clock, synchronous active-high reset
//   i_redirect      : load i_redirect_pc into pc (highest priority)
//   i_redirect_pc   : redirect target
//   i_advance       : load i_advance_base + INST_BYTES into pc
//   i_advance_base  : address of the word just fetched
//   o_pc            : current pc
//   o_misaligned    : current pc is not word aligned
// -----------------------------------------------------------------------------
module cpu_pc_reg
  import cpu_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_advance,
  input  logic [XLEN-1:0] i_advance_base,
  output logic [XLEN-1:0] o_pc,
  output logic            o_misaligned
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_plus4;

  // Wraps modulo 2^XLEN naturally; the carry out is intentionally dropped.
  assign w_pc_plus4 = i_advance_base + XLEN'(INST_BYTES);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (i_redirect) begin
      r_pc <= i_redirect_pc;
    end else if (i_advance) begin
      r_pc <= w_pc_plus4;
    end
  end

  assign o_pc         = r_pc;
  assign o_misaligned = is_misaligned(r_pc);

endmodule

// File: rtl/cpu_fetch_unit.sv
// -----------------------------------------------------------------------------
// cpu_fetch_unit
// Instruction fetch stage: holds the PC, performs one bus read per fetch
// request and writes the returned word into the IR.
//   clk, rst          : clock, synchronous active-high reset
//   fetch_start       : fetch request at current pc (level, sampled in IDLE)
//   pc_wr, pc_in      : redirect from execute
//   mem_addr, mem_rd  : bus read address / strobe
//   mem_data_in       : bus read data, valid with mem_ack
//   mem_ack           : one-cycle bus completion
//   ir_data, ir_wr    : word and write enable towards the IR (combinational)
//   pc                : address of next instruction to fetch
//   inst_pc           : address of the instruction held in the IR
//   busy              : fetch in progress
//   fetch_done        : pulse, cycle after IR written
//   fault_misaligned  : pulse, fetch attempted at unaligned pc
//   fault_bus         : pulse, bus did not acknowledge within TIMEOUT cycles
// -----------------------------------------------------------------------------
module cpu_fetch_unit
  import cpu_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [7:0]      TIMEOUT  = 8'd255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_start,
  input  logic            pc_wr,
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_rd,
  input  logic [XLEN-1:0] mem_data_in,
  input  logic            mem_ack,
  output logic [XLEN-1:0] ir_data,
  output logic            ir_wr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] inst_pc,
  output logic            busy,
  output logic            fetch_done,
  output logic            fault_misaligned,
  output logic            fault_bus
);

  localparam logic [7:0] TMO_LAST = TIMEOUT - 8'd1;

  fetch_state_e    r_state,    w_state_nxt;
  logic [XLEN-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [XLEN-1:0] r_inst_pc,  w_inst_pc_nxt;
  logic [XLEN-1:0] r_target,   w_target_nxt;
  logic            r_pending,  w_pending_nxt;
  logic            r_restart,  w_restart_nxt;
  logic [7:0]      r_cnt,      w_cnt_nxt;
  logic            r_fetch_done, r_fault_mis, r_fault_bus;
  logic            w_fault_mis_nxt, w_fault_bus_nxt;

  logic            w_pc_redirect;
  logic [XLEN-1:0] w_pc_redirect_val;
  logic            w_pc_advance;
  logic [XLEN-1:0] w_pc;
  logic            w_pc_misaligned;
  logic            w_redirect;
  logic [XLEN-1:0] w_target_now;

  cpu_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk            (clk),
    .rst            (rst),
    .i_redirect     (w_pc_redirect),
    .i_redirect_pc  (w_pc_redirect_val),
    .i_advance      (w_pc_advance),
    .i_advance_base (r_mem_addr),
    .o_pc           (w_pc),
    .o_misaligned   (w_pc_misaligned)
  );

  // A redirect arriving in the same cycle as the ack still wins over the
  // in-flight word; the latest pc_wr value is the effective target.
  assign w_redirect   = r_pending | pc_wr;
  assign w_target_now = pc_wr ? pc_in : r_target;

  // State register. Every register here is reset, including the datapath
  // ones, so reset alone defines all outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= FETCH_IDLE;
      r_mem_addr   <= RESET_PC;
      r_inst_pc    <= RESET_PC;
      r_target     <= RESET_PC;
      r_pending    <= 1'b0;
      r_restart    <= 1'b0;
      r_cnt        <= 8'd0;
      r_fetch_done <= 1'b0;
      r_fault_mis  <= 1'b0;
      r_fault_bus  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_inst_pc    <= w_inst_pc_nxt;
      r_target     <= w_target_nxt;
      r_pending    <= w_pending_nxt;
      r_restart    <= w_restart_nxt;
      r_cnt        <= w_cnt_nxt;
      r_fetch_done <= ir_wr;
      r_fault_mis  <= w_fault_mis_nxt;
      r_fault_bus  <= w_fault_bus_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    w_state_nxt       = r_state;
    w_mem_addr_nxt    = r_mem_addr;
    w_inst_pc_nxt     = r_inst_pc;
    w_target_nxt      = r_target;
    w_pending_nxt     = r_pending;
    w_restart_nxt     = r_restart;
    w_cnt_nxt         = r_cnt;
    w_fault_mis_nxt   = 1'b0;
    w_fault_bus_nxt   = 1'b0;
    w_pc_redirect     = 1'b0;
    w_pc_redirect_val = pc_in;
    w_pc_advance      = 1'b0;

    unique case (r_state)
      FETCH_IDLE: begin
        if (pc_wr) begin
          // Redirect beats a fetch request so the stale pc is never fetched.
          w_pc_redirect = 1'b1;
        end else if (fetch_start || r_restart) begin
          w_restart_nxt = 1'b0;
          if (w_pc_misaligned) begin
            w_fault_mis_nxt = 1'b1;
          end else begin
            w_state_nxt    = FETCH_BUSY;
            w_mem_addr_nxt = w_pc;
            w_cnt_nxt      = 8'd0;
          end
        end
      end

      FETCH_BUSY: begin
        if (pc_wr) begin
          w_pending_nxt = 1'b1;
          w_target_nxt  = pc_in;
        end
        if (mem_ack) begin
          w_state_nxt = FETCH_IDLE;
          w_cnt_nxt   = 8'd0;
          if (w_redirect) begin
            // Discard the returned word and fetch from the target instead,
            // via one IDLE cycle so mem_rd drops between the two reads.
            w_pending_nxt     = 1'b0;
            w_pc_redirect     = 1'b1;
            w_pc_redirect_val = w_target_now;
            if (is_misaligned(w_target_now)) begin
              w_fault_mis_nxt = 1'b1;
            end else begin
              w_restart_nxt = 1'b1;
            end
          end else begin
            w_inst_pc_nxt = r_mem_addr;
            w_pc_advance  = 1'b1;
          end
        end else if (r_cnt == TMO_LAST) begin
          w_state_nxt     = FETCH_IDLE;
          w_cnt_nxt       = 8'd0;
          w_fault_bus_nxt = 1'b1;
          if (w_redirect) begin
            w_pending_nxt     = 1'b0;
            w_pc_redirect     = 1'b1;
            w_pc_redirect_val = w_target_now;
          end
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end

      default: w_state_nxt = FETCH_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    busy  = (r_state == FETCH_BUSY);
    // A word is written only when nothing redirected the fetch; an ack seen
    // while reset is asserted belongs to an abandoned fetch.
    ir_wr = busy && mem_ack && !w_redirect && !rst;
  end

  assign mem_rd           = busy;
  assign mem_addr         = r_mem_addr;
  assign ir_data          = mem_data_in;
  assign pc               = w_pc;
  assign inst_pc          = r_inst_pc;
  assign fetch_done       = r_fetch_done;
  assign fault_misaligned = r_fault_mis;
  assign fault_bus        = r_fault_bus;

endmodule
